// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_REQ  = 3'd1,
        ST_D_WAIT = 3'd2,
        ST_I_REQ  = 3'd3,
        ST_I_WAIT = 3'd4
    } state_e;

    typedef enum logic {
        GRANT_DATA = 1'b0,
        GRANT_INST = 1'b1
    } grant_e;

    // Load attributes latched at issue, needed when read data returns.
    typedef struct packed {
        logic [1:0] mtype;
        logic       sign;
        logic [1:0] lo;
    } acc_t;

    function automatic logic is_misaligned(input logic [1:0] mtype, input logic [1:0] lo);
        case (mtype)
            MEM_B:   return 1'b0;
            MEM_H:   return lo[0];
            default: return (lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores, extraction/extension for loads, misalign detect.
module mem_align
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  st_lo,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strb_c,
    output logic [31:0] st_data_c,
    output logic        misalign_c,
    input  logic [1:0]  ld_lo,
    input  logic [1:0]  ld_type,
    input  logic        ld_sign,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign misalign_c = is_misaligned(st_type, st_lo);

    always_comb begin
        st_strb_c = 4'b1111;
        st_data_c = st_data;
        case (st_type)
            MEM_B: begin
                st_strb_c = 4'b0001 << st_lo;
                st_data_c = {4{st_data[7:0]}};
            end
            MEM_H: begin
                st_strb_c = st_lo[1] ? 4'b1100 : 4'b0011;
                st_data_c = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_lo)
            2'd0:    ld_byte = ld_raw[7:0];
            2'd1:    ld_byte = ld_raw[15:8];
            2'd2:    ld_byte = ld_raw[23:16];
            default: ld_byte = ld_raw[31:24];
        endcase
        ld_half = ld_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
        case (ld_type)
            MEM_B:   ld_data_c = ld_sign ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
            MEM_H:   ld_data_c = ld_sign ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
            default: ld_data_c = ld_raw;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one variable-latency memory bus between instruction fetch and
// the MEM-stage data port; data has priority but fetch gets every other slot.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          d_rmem,
    input  logic          d_wmem,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [1:0]    d_type,
    input  logic          d_sign,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_err,
    output logic          d_stall,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [3:0]    bus_wstrb,
    input  logic          bus_gnt,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata
);

    state_e        state_q, state_d;
    grant_e        last_grant_q, last_grant_d;
    logic          arb_if_q, arb_if_d;
    logic          drop_fetch_q, drop_fetch_d;
    acc_t          acc_q, acc_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]    bus_wstrb_q, bus_wstrb_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          d_err_q, d_err_d;

    logic          data_pend;
    logic          arb_ok;
    logic          fetch_win;
    logic [3:0]    st_strb_c;
    logic [31:0]   st_data_c;
    logic          misalign_c;
    logic [31:0]   ld_data_c;

    mem_align u_align (
        .st_lo      (d_addr[1:0]),
        .st_type    (d_type),
        .st_data    (d_wdata),
        .st_strb_c  (st_strb_c),
        .st_data_c  (st_data_c),
        .misalign_c (misalign_c),
        .ld_lo      (acc_q.lo),
        .ld_type    (acc_q.mtype),
        .ld_sign    (acc_q.sign),
        .ld_raw     (bus_rdata),
        .ld_data_c  (ld_data_c)
    );

    assign data_pend = d_rmem | d_wmem;
    // A completion pulse in flight means the requester has not yet dropped its request.
    assign arb_ok    = ~if_valid_q & ~d_valid_q;
    assign fetch_win = if_req & (~data_pend | ((last_grant_q == GRANT_DATA) & arb_if_q));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        arb_if_d     = arb_if_q;
        drop_fetch_d = drop_fetch_q;
        acc_d        = acc_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_valid_d   = 1'b0;
        d_valid_d    = 1'b0;
        d_err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                drop_fetch_d = 1'b0;
                if (arb_ok && (data_pend || if_req)) begin
                    arb_if_d = if_req;
                    if (fetch_win) begin
                        last_grant_d = GRANT_INST;
                        state_d      = ST_I_REQ;
                        bus_req_d    = 1'b1;
                        bus_we_d     = 1'b0;
                        bus_addr_d   = if_addr & ~AW'(3);
                        bus_wstrb_d  = 4'b0000;
                        bus_wdata_d  = '0;
                    end else begin
                        last_grant_d = GRANT_DATA;
                        if (misalign_c) begin
                            d_valid_d = 1'b1;
                            d_err_d   = 1'b1;
                            d_rdata_d = '0;
                        end else begin
                            state_d     = ST_D_REQ;
                            bus_req_d   = 1'b1;
                            bus_we_d    = d_wmem;
                            bus_addr_d  = d_addr & ~AW'(3);
                            bus_wstrb_d = d_wmem ? st_strb_c : 4'b0000;
                            bus_wdata_d = d_wmem ? DW'(st_data_c) : '0;
                            acc_d       = '{mtype: d_type, sign: d_sign, lo: d_addr[1:0]};
                        end
                    end
                end
            end
            ST_D_REQ: begin
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    if (bus_we_q) begin
                        d_valid_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_D_WAIT;
                    end
                end
            end
            ST_D_WAIT: begin
                if (bus_rvalid) begin
                    d_rdata_d = DW'(ld_data_c);
                    d_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_I_REQ: begin
                if (if_flush) drop_fetch_d = 1'b1;
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_I_WAIT;
                end
            end
            ST_I_WAIT: begin
                if (if_flush) drop_fetch_d = 1'b1;
                // A flushed fetch still drains its read beat, it just is not reported.
                if (bus_rvalid) begin
                    if_rdata_d   = bus_rdata;
                    if_valid_d   = ~(drop_fetch_q | if_flush);
                    drop_fetch_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_DATA;
            arb_if_q     <= 1'b0;
            drop_fetch_q <= 1'b0;
            acc_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wstrb_q  <= 4'b0000;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_valid_q   <= 1'b0;
            d_valid_q    <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            arb_if_q     <= arb_if_d;
            drop_fetch_q <= drop_fetch_d;
            acc_q        <= acc_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_valid_q   <= if_valid_d;
            d_valid_q    <= d_valid_d;
            d_err_q      <= d_err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign if_stall  = if_req & ~if_valid_q;
    assign d_stall   = data_pend & ~d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs driven and outputs sampled 1ns after posedge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_valid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_rmem, d_wmem, d_sign, d_valid, d_err, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_type;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .d_rmem(d_rmem), .d_wmem(d_wmem), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_type(d_type), .d_sign(d_sign), .d_rdata(d_rdata), .d_valid(d_valid),
        .d_err(d_err), .d_stall(d_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        nvec++;
        if ({bus_req, bus_we, if_valid, d_valid, d_err} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_ctrl: got %b want 00000", {bus_req, bus_we, if_valid, d_valid, d_err});
        end
        nvec++;
        if ({bus_addr, bus_wdata, bus_wstrb} !== 68'h0) begin
            nerr++;
            $display("FAIL reset_bus: got %h want 0", {bus_addr, bus_wdata, bus_wstrb});
        end
        nvec++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            nerr++;
            $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_stores();
        logic [31:0] a [5];
        logic [1:0]  t [5];
        logic [31:0] w [5];
        logic [31:0] ea [5];
        logic [3:0]  es [5];
        logic [31:0] ew [5];
        a  = '{32'h1003, 32'h1000, 32'h1006, 32'h1004, 32'h1008};
        t  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        w  = '{32'h000000A5, 32'h12345678, 32'h0000BEEF, 32'hFFFF1234, 32'hCAFEF00D};
        ea = '{32'h1000, 32'h1000, 32'h1004, 32'h1004, 32'h1008};
        es = '{4'b1000, 4'b0001, 4'b1100, 4'b0011, 4'b1111};
        ew = '{32'hA5A5A5A5, 32'h78787878, 32'hBEEFBEEF, 32'h12341234, 32'hCAFEF00D};
        for (int i = 0; i < 5; i++) begin
            d_wmem = 1'b1; d_addr = a[i]; d_type = t[i]; d_wdata = w[i]; bus_gnt = 1'b1;
            tick();
            nvec++;
            if ({bus_req, bus_we, d_stall} !== 3'b111) begin
                nerr++;
                $display("FAIL st%0d_req: got %b want 111", i, {bus_req, bus_we, d_stall});
            end
            nvec++;
            if (bus_addr !== ea[i]) begin
                nerr++;
                $display("FAIL st%0d_addr: got %h want %h", i, bus_addr, ea[i]);
            end
            nvec++;
            if (bus_wstrb !== es[i]) begin
                nerr++;
                $display("FAIL st%0d_wstrb: got %b want %b", i, bus_wstrb, es[i]);
            end
            nvec++;
            if (bus_wdata !== ew[i]) begin
                nerr++;
                $display("FAIL st%0d_wdata: got %h want %h", i, bus_wdata, ew[i]);
            end
            tick();
            nvec++;
            if ({d_valid, d_err, bus_req, d_stall} !== 4'b1000) begin
                nerr++;
                $display("FAIL st%0d_done: got %b want 1000", i, {d_valid, d_err, bus_req, d_stall});
            end
            d_wmem = 1'b0; bus_gnt = 1'b0;
            tick();
            nvec++;
            if (d_valid !== 1'b0) begin
                nerr++;
                $display("FAIL st%0d_pulse: got %b want 0", i, d_valid);
            end
        end
    endtask

    task automatic test_loads();
        logic [31:0] a [6];
        logic [1:0]  t [6];
        logic        s [6];
        logic [31:0] r [6];
        logic [31:0] ea [6];
        logic [31:0] ex [6];
        a  = '{32'h2002, 32'h2001, 32'h2003, 32'h2000, 32'h2004, 32'h2000};
        t  = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
        s  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        r  = '{32'h80011234, 32'h80011234, 32'h80011234, 32'h80011234, 32'hDEADBEEF, 32'h000000F0};
        ea = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h2004, 32'h2000};
        ex = '{32'hFFFF8001, 32'h00000012, 32'hFFFFFF80, 32'h00001234, 32'hDEADBEEF, 32'hFFFFFFF0};
        for (int i = 0; i < 6; i++) begin
            d_rmem = 1'b1; d_addr = a[i]; d_type = t[i]; d_sign = s[i]; bus_gnt = 1'b1;
            tick();
            nvec++;
            if ({bus_req, bus_we} !== 2'b10 || bus_addr !== ea[i]) begin
                nerr++;
                $display("FAIL ld%0d_req: got req/we %b addr %h want 10 addr %h", i, {bus_req, bus_we}, bus_addr, ea[i]);
            end
            tick();
            bus_gnt = 1'b0;
            tick();
            nvec++;
            if ({bus_req, d_valid} !== 2'b00) begin
                nerr++;
                $display("FAIL ld%0d_wait: got %b want 00", i, {bus_req, d_valid});
            end
            bus_rvalid = 1'b1; bus_rdata = r[i];
            tick();
            nvec++;
            if ({d_valid, d_err} !== 2'b10 || d_rdata !== ex[i]) begin
                nerr++;
                $display("FAIL ld%0d_data: got v/e %b data %h want 10 data %h", i, {d_valid, d_err}, d_rdata, ex[i]);
            end
            bus_rvalid = 1'b0; d_rmem = 1'b0; d_sign = 1'b0;
            tick();
        end
    endtask

    task automatic test_priority();
        if_req = 1'b1; if_addr = 32'h100;
        d_rmem = 1'b1; d_addr = 32'h3000; d_type = 2'b10;
        tick();
        nvec++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h3000) begin
            nerr++;
            $display("FAIL prio_first_data: got req %b addr %h want 1 addr 00003000", bus_req, bus_addr);
        end
        nvec++;
        if ({if_stall, d_stall} !== 2'b11) begin
            nerr++;
            $display("FAIL prio_stalls: got %b want 11", {if_stall, d_stall});
        end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
        tick();
        nvec++;
        if (d_valid !== 1'b1 || d_rdata !== 32'h11111111 || if_valid !== 1'b0) begin
            nerr++;
            $display("FAIL prio_data1_done: got dv %b data %h iv %b want 1 11111111 0", d_valid, d_rdata, if_valid);
        end
        bus_rvalid = 1'b0;
        tick();
        tick();
        nvec++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h100) begin
            nerr++;
            $display("FAIL prio_fetch_turn: got req %b addr %h want 1 addr 00000100", bus_req, bus_addr);
        end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h00000013;
        tick();
        nvec++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h00000013 || d_valid !== 1'b0) begin
            nerr++;
            $display("FAIL prio_fetch_done: got iv %b data %h dv %b want 1 00000013 0", if_valid, if_rdata, d_valid);
        end
        bus_rvalid = 1'b0; if_addr = 32'h104;
        tick();
        tick();
        nvec++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h3000) begin
            nerr++;
            $display("FAIL prio_data_again: got req %b addr %h want 1 addr 00003000", bus_req, bus_addr);
        end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h00000022;
        tick();
        nvec++;
        if (d_valid !== 1'b1 || d_rdata !== 32'h00000022) begin
            nerr++;
            $display("FAIL prio_data2_done: got dv %b data %h want 1 00000022", d_valid, d_rdata);
        end
        bus_rvalid = 1'b0; d_rmem = 1'b0; if_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h200;
        tick();
        nvec++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h200) begin
            nerr++;
            $display("FAIL flush_issue: got req %b addr %h want 1 addr 00000200", bus_req, bus_addr);
        end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; if_flush = 1'b1;
        tick();
        if_flush = 1'b0; if_addr = 32'h300;
        tick();
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'h00000BAD;
        tick();
        nvec++;
        if ({if_valid, bus_req, if_stall} !== 3'b001) begin
            nerr++;
            $display("FAIL flush_dropped: got iv/req/stall %b want 001", {if_valid, bus_req, if_stall});
        end
        bus_rvalid = 1'b0;
        tick();
        nvec++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h300 || if_valid !== 1'b0) begin
            nerr++;
            $display("FAIL flush_next_issue: got req %b addr %h iv %b want 1 00000300 0", bus_req, bus_addr, if_valid);
        end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h00000093;
        tick();
        nvec++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h00000093 || if_stall !== 1'b0) begin
            nerr++;
            $display("FAIL flush_next_done: got iv %b data %h stall %b want 1 00000093 0", if_valid, if_rdata, if_stall);
        end
        bus_rvalid = 1'b0; if_req = 1'b0;
        tick();
    endtask

    task automatic test_misalign();
        d_rmem = 1'b1; d_addr = 32'h3002; d_type = 2'b10;
        tick();
        nvec++;
        if ({d_valid, d_err, bus_req} !== 3'b110 || d_rdata !== 32'h0) begin
            nerr++;
            $display("FAIL mis_lw: got v/e/req %b data %h want 110 data 0", {d_valid, d_err, bus_req}, d_rdata);
        end
        d_rmem = 1'b0;
        tick();
        nvec++;
        if ({d_valid, d_err, bus_req} !== 3'b000) begin
            nerr++;
            $display("FAIL mis_lw_clear: got %b want 000", {d_valid, d_err, bus_req});
        end
        d_wmem = 1'b1; d_addr = 32'h3001; d_type = 2'b01;
        tick();
        nvec++;
        if ({d_valid, d_err, bus_req} !== 3'b110) begin
            nerr++;
            $display("FAIL mis_sh: got %b want 110", {d_valid, d_err, bus_req});
        end
        d_wmem = 1'b0;
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'h77777777;
        tick();
        nvec++;
        if ({d_valid, if_valid, bus_req} !== 3'b000) begin
            nerr++;
            $display("FAIL idle_rvalid: got %b want 000", {d_valid, if_valid, bus_req});
        end
        bus_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        d_rmem = 1'b1; d_addr = 32'h4000; d_type = 2'b10;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; rst = 1'b1;
        tick();
        nvec++;
        if ({bus_req, d_valid} !== 2'b00) begin
            nerr++;
            $display("FAIL rstmid_req: got %b want 00", {bus_req, d_valid});
        end
        rst = 1'b0; d_rmem = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
        tick();
        nvec++;
        if ({bus_req, d_valid} !== 2'b00 || d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
            nerr++;
            $display("FAIL rstmid_late_rvalid: got req/dv %b d %h i %h want 00 0 0", {bus_req, d_valid}, d_rdata, if_rdata);
        end
        bus_rvalid = 1'b0;
        tick();
        nvec++;
        if ({bus_req, d_valid, if_valid} !== 3'b000) begin
            nerr++;
            $display("FAIL rstmid_quiet: got %b want 000", {bus_req, d_valid, if_valid});
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_rmem = 1'b0; d_wmem = 1'b0; d_addr = '0; d_wdata = '0; d_type = 2'b00; d_sign = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        test_reset();
        test_stores();
        test_loads();
        test_priority();
        test_flush();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
